// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bp_pkg
//  Brief    : Shared types and helpers for the dynamic branch predictor:
//             2-bit counter encoding, BTB entry and shadow-slot records.
//  Revision : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // Storage width for PCs/targets/tags inside the records. Any DATA_WIDTH up
  // to this value is supported; unused upper bits are always stored as zero.
  localparam int BP_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_e;

  localparam bp_ctr_e BP_CTR_RESET = WNT;

  typedef struct packed {
    logic                    valid;
    logic [BP_MAX_WIDTH-1:0] tag;
    logic [BP_MAX_WIDTH-1:0] target;
    bp_ctr_e                 ctr;
  } bp_entry_t;

  typedef struct packed {
    logic                    valid;
    logic                    pred_taken;
    logic [BP_MAX_WIDTH-1:0] pred_target;
  } bp_slot_t;

  localparam bp_entry_t BP_ENTRY_RESET = '{valid: 1'b0, tag: '0, target: '0, ctr: BP_CTR_RESET};
  localparam bp_slot_t  BP_SLOT_EMPTY  = '{valid: 1'b0, pred_taken: 1'b0, pred_target: '0};

  // Saturating 2-bit counter step: taken moves toward ST, not-taken toward SNT.
  function automatic bp_ctr_e bp_ctr_next(input bp_ctr_e ctr, input logic taken);
    bp_ctr_e nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = bp_ctr_e'(ctr + 2'd1);
    end else begin
      if (ctr != SNT) nxt = bp_ctr_e'(ctr - 2'd1);
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor_if
//  Brief    : Pipeline <-> branch predictor signal bundle. The pipeline side
//             (fetch, hazard unit, execute) is the master; the predictor is
//             the slave.
//  Revision : 1.0 - initial release
// ============================================================================
interface branch_predictor_if #(
  parameter int DATA_WIDTH = 32
);
  // Fetch
  logic [DATA_WIDTH-1:0] pcF;
  logic                  predictTakenF;
  logic [DATA_WIDTH-1:0] predictTargetF;
  // Hazard unit control
  logic                  stall;
  logic                  flush;
  // Execute resolution
  logic                  branchE;
  logic                  takenE;
  logic [DATA_WIDTH-1:0] pcE;
  logic [DATA_WIDTH-1:0] targetE;
  // Results
  logic                  branch;
  logic                  branchResolved;
  logic                  redirectValid;
  logic [DATA_WIDTH-1:0] redirectPC;

  modport master (
    output pcF, stall, flush, branchE, takenE, pcE, targetE,
    input  predictTakenF, predictTargetF, branch, branchResolved,
           redirectValid, redirectPC
  );

  modport slave (
    input  pcF, stall, flush, branchE, takenE, pcE, targetE,
    output predictTakenF, predictTargetF, branch, branchResolved,
           redirectValid, redirectPC
  );
endinterface
`default_nettype wire

// File: rtl/bp_table.sv
`default_nettype none
// ============================================================================
//  Module   : bp_table
//  Brief    : Direct-mapped BTB with 2-bit counters. One asynchronous read
//             port for fetch, one synchronous update port from Execute.
//             A same-cycle read of the entry being written returns the old
//             value.
//  Revision : 1.0 - initial release
// ============================================================================
module bp_table
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rd_pc_i,
  output logic                  rd_taken_o,
  output logic [DATA_WIDTH-1:0] rd_target_o,
  input  logic                  upd_en_i,
  input  logic                  upd_taken_i,
  input  logic [DATA_WIDTH-1:0] upd_pc_i,
  input  logic [DATA_WIDTH-1:0] upd_target_i
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  bp_entry_t               entry_q [ENTRIES];
  bp_entry_t               rd_entry;
  bp_entry_t               upd_old;
  bp_entry_t               upd_entry_d;
  logic                    upd_we;
  logic                    rd_hit;
  logic                    upd_hit;
  logic [INDEX_BITS-1:0]   rd_idx;
  logic [INDEX_BITS-1:0]   upd_idx;
  logic [BP_MAX_WIDTH-1:0] rd_tag;
  logic [BP_MAX_WIDTH-1:0] upd_tag;
  logic                    unused_pc_bits;

  // Word-aligned PCs: the two low bits never select or tag an entry.
  assign unused_pc_bits = ^{rd_pc_i[1:0], upd_pc_i[1:0]};

  assign rd_idx  = rd_pc_i[INDEX_BITS+1:2];
  assign upd_idx = upd_pc_i[INDEX_BITS+1:2];
  assign rd_tag  = BP_MAX_WIDTH'(rd_pc_i >> (INDEX_BITS + 2));
  assign upd_tag = BP_MAX_WIDTH'(upd_pc_i >> (INDEX_BITS + 2));

  // Fetch lookup: predict taken only on a tag hit with the counter's MSB set.
  always_comb begin
    rd_entry    = entry_q[rd_idx];
    rd_hit      = rd_entry.valid && (rd_entry.tag == rd_tag);
    rd_taken_o  = rd_hit && rd_entry.ctr[1];
    rd_target_o = DATA_WIDTH'(rd_entry.target);
  end

  // Update: taken always (re)writes the entry; not-taken only trains a hit.
  always_comb begin
    upd_old     = entry_q[upd_idx];
    upd_hit     = upd_old.valid && (upd_old.tag == upd_tag);
    upd_entry_d = upd_old;
    upd_we      = 1'b0;
    if (upd_en_i) begin
      if (upd_taken_i) begin
        upd_we             = 1'b1;
        upd_entry_d.valid  = 1'b1;
        upd_entry_d.tag    = upd_tag;
        upd_entry_d.target = BP_MAX_WIDTH'(upd_target_i);
        // A fresh allocation starts weakly taken rather than training the
        // counter left behind by the aliasing branch.
        upd_entry_d.ctr    = upd_hit ? bp_ctr_next(upd_old.ctr, 1'b1) : WT;
      end else if (upd_hit) begin
        upd_we          = 1'b1;
        upd_entry_d.ctr = bp_ctr_next(upd_old.ctr, 1'b0);
      end
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    // Entry storage; reset wins over any pending update.
    always_ff @(posedge clk) begin
      if (rst) begin
        entry_q[i] <= BP_ENTRY_RESET;
      end else if (upd_we && (upd_idx == INDEX_BITS'(i))) begin
        entry_q[i] <= upd_entry_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor
//  Brief    : Dynamic branch predictor top. Predicts at fetch through
//             bp_table, carries each prediction through D and E shadow slots
//             and checks it against the resolved branch in Execute.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  branch_predictor_if.slave  bp
);

  logic                  fetch_taken;
  logic [DATA_WIDTH-1:0] fetch_target;
  logic                  mispredict;
  bp_slot_t              fetch_slot;
  bp_slot_t              dslot_q;
  bp_slot_t              dslot_d;
  bp_slot_t              eslot_q;
  bp_slot_t              eslot_d;

  bp_table #(
    .INDEX_BITS (INDEX_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_table (
    .clk          (clk),
    .rst          (rst),
    .rd_pc_i      (bp.pcF),
    .rd_taken_o   (fetch_taken),
    .rd_target_o  (fetch_target),
    .upd_en_i     (bp.branchE),
    .upd_taken_i  (bp.takenE),
    .upd_pc_i     (bp.pcE),
    .upd_target_i (bp.targetE)
  );

  // Fetch prediction and the record that travels with the instruction.
  always_comb begin
    bp.predictTakenF       = fetch_taken;
    bp.predictTargetF      = fetch_taken ? fetch_target : bp.pcF + DATA_WIDTH'(4);
    fetch_slot             = BP_SLOT_EMPTY;
    fetch_slot.valid       = 1'b1;
    fetch_slot.pred_taken  = fetch_taken;
    fetch_slot.pred_target = BP_MAX_WIDTH'(bp.predictTargetF);
  end

  // Compare the E-slot prediction with the resolved outcome. An empty slot
  // means fetch never predicted this branch, so it always redirects.
  always_comb begin
    mispredict = 1'b0;
    if (bp.branchE) begin
      mispredict = !eslot_q.valid
                || (bp.takenE != eslot_q.pred_taken)
                || (bp.takenE && (eslot_q.pred_target != BP_MAX_WIDTH'(bp.targetE)));
    end
    bp.branch         = bp.branchE;
    bp.branchResolved = bp.branchE && !mispredict;
    bp.redirectValid  = mispredict;
    bp.redirectPC     = bp.takenE ? bp.targetE : bp.pcE + DATA_WIDTH'(4);
  end

  // Shadow-slot next state: a redirect squashes both slots, even under stall.
  always_comb begin
    dslot_d = dslot_q;
    eslot_d = dslot_q;
    if (mispredict) begin
      dslot_d = BP_SLOT_EMPTY;
    end else if (!bp.stall) begin
      dslot_d = fetch_slot;
    end
    if (mispredict || bp.flush) begin
      eslot_d = BP_SLOT_EMPTY;
    end
  end

  // Shadow-slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dslot_q <= BP_SLOT_EMPTY;
      eslot_q <= BP_SLOT_EMPTY;
    end else begin
      dslot_q <= dslot_d;
      eslot_q <= eslot_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_predictor
//  Brief    : Directed, table-driven bench for branch_predictor
//             (INDEX_BITS=4, DATA_WIDTH=32).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  branch_predictor_if #(.DATA_WIDTH(32)) bus ();

  branch_predictor #(
    .INDEX_BITS (4),
    .DATA_WIDTH (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc_f;
    logic        st;
    logic        fl;
    logic        br;
    logic        tk;
    logic [31:0] pc_e;
    logic [31:0] tgt_e;
    logic        x_pt;
    logic [31:0] x_ptgt;
    logic        x_redir;
    logic [31:0] x_rpc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [31:0] pc_f, input logic st, input logic fl,
                     input logic br, input logic tk, input logic [31:0] pc_e,
                     input logic [31:0] tgt_e, input logic x_pt,
                     input logic [31:0] x_ptgt, input logic x_redir,
                     input logic [31:0] x_rpc);
    vec_t v;
    v.pc_f = pc_f; v.st = st; v.fl = fl; v.br = br; v.tk = tk;
    v.pc_e = pc_e; v.tgt_e = tgt_e; v.x_pt = x_pt; v.x_ptgt = x_ptgt;
    v.x_redir = x_redir; v.x_rpc = x_rpc;
    vq.push_back(v);
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc_f, input logic st, input logic fl,
                       input logic br, input logic tk, input logic [31:0] pc_e,
                       input logic [31:0] tgt_e);
    bus.pcF     = pc_f;
    bus.stall   = st;
    bus.flush   = fl;
    bus.branchE = br;
    bus.takenE  = tk;
    bus.pcE     = pc_e;
    bus.targetE = tgt_e;
  endtask

  // Combinational fetch check without advancing the clock.
  task automatic peek_fetch(input string nm, input logic [31:0] pc_f,
                            input logic x_pt, input logic [31:0] x_ptgt);
    bus.pcF = pc_f;
    #1;
    cmp({nm, " predictTakenF"}, 32'(bus.predictTakenF), 32'(x_pt));
    cmp({nm, " predictTargetF"}, bus.predictTargetF, x_ptgt);
  endtask

  // One cycle: drive at posedge+1, check mid-cycle, advance to next posedge+1.
  task automatic step(input string nm, input vec_t v);
    drive(v.pc_f, v.st, v.fl, v.br, v.tk, v.pc_e, v.tgt_e);
    #4;
    cmp({nm, " predictTakenF"},  32'(bus.predictTakenF),  32'(v.x_pt));
    cmp({nm, " predictTargetF"}, bus.predictTargetF,      v.x_ptgt);
    cmp({nm, " redirectValid"},  32'(bus.redirectValid),  32'(v.x_redir));
    cmp({nm, " redirectPC"},     bus.redirectPC,          v.x_rpc);
    cmp({nm, " branch"},         32'(bus.branch),         32'(v.br));
    cmp({nm, " branchResolved"}, 32'(bus.branchResolved), 32'(v.br && !v.x_redir));
    @(posedge clk);
    #1;
  endtask

  task automatic step_args(input string nm, input logic [31:0] pc_f, input logic st,
                           input logic fl, input logic br, input logic tk,
                           input logic [31:0] pc_e, input logic [31:0] tgt_e,
                           input logic x_pt, input logic [31:0] x_ptgt,
                           input logic x_redir, input logic [31:0] x_rpc);
    vec_t v;
    v.pc_f = pc_f; v.st = st; v.fl = fl; v.br = br; v.tk = tk;
    v.pc_e = pc_e; v.tgt_e = tgt_e; v.x_pt = x_pt; v.x_ptgt = x_ptgt;
    v.x_redir = x_redir; v.x_rpc = x_rpc;
    step(nm, v);
  endtask

  initial begin
    // Main cycle-by-cycle script:
    //   pcF  st fl br tk pcE targetE | predT predTgt redir redirPC
    add(32'h100, 0,0, 0,0, 32'h0,   32'h0,   0, 32'h104, 0, 32'h4);   // 0  reset state
    add(32'h104, 0,0, 0,0, 32'h0,   32'h0,   0, 32'h108, 0, 32'h4);   // 1
    add(32'h108, 0,0, 1,1, 32'h100, 32'h80,  0, 32'h10C, 1, 32'h80);  // 2  first sight, taken
    add(32'h100, 0,0, 0,0, 32'h0,   32'h0,   1, 32'h80,  0, 32'h4);   // 3  now predicted taken
    add(32'h080, 0,0, 0,0, 32'h0,   32'h0,   0, 32'h84,  0, 32'h4);   // 4  0x80 aliases, tag miss
    add(32'h100, 0,0, 1,1, 32'h100, 32'h80,  1, 32'h80,  0, 32'h80);  // 5  correct, WT->ST
    add(32'h084, 0,0, 0,0, 32'h0,   32'h0,   0, 32'h88,  0, 32'h4);   // 6
    add(32'h100, 0,0, 1,1, 32'h100, 32'h80,  1, 32'h80,  0, 32'h80);  // 7  correct, ST
    add(32'h084, 0,0, 0,0, 32'h0,   32'h0,   0, 32'h88,  0, 32'h4);   // 8
    add(32'h100, 0,0, 1,1, 32'h100, 32'h80,  1, 32'h80,  0, 32'h80);  // 9  fourth taken
    add(32'h084, 0,0, 0,0, 32'h0,   32'h0,   0, 32'h88,  0, 32'h4);   // 10
    add(32'h100, 0,0, 1,0, 32'h100, 32'h80,  1, 32'h80,  1, 32'h104); // 11 not taken -> redirect
    add(32'h100, 0,0, 0,0, 32'h0,   32'h0,   1, 32'h80,  0, 32'h4);   // 12 WT still taken
    add(32'h140, 0,0, 0,0, 32'h0,   32'h0,   0, 32'h144, 0, 32'h4);   // 13 alias tag miss
    add(32'h104, 0,0, 0,0, 32'h0,   32'h0,   0, 32'h108, 0, 32'h4);   // 14
    add(32'h108, 0,0, 1,1, 32'h140, 32'h200, 0, 32'h10C, 1, 32'h200); // 15 0x140 overwrites entry
    add(32'h100, 0,0, 0,0, 32'h0,   32'h0,   0, 32'h104, 0, 32'h4);   // 16 0x100 lost
    add(32'h140, 0,0, 0,0, 32'h0,   32'h0,   1, 32'h200, 0, 32'h4);   // 17
    add(32'h10C, 0,0, 1,0, 32'h100, 32'h0,   0, 32'h110, 0, 32'h104); // 18 NT miss: no alloc
    add(32'h140, 0,0, 1,1, 32'h140, 32'h200, 1, 32'h200, 0, 32'h200); // 19 entry intact, correct
    add(32'h140, 0,0, 0,0, 32'h0,   32'h0,   1, 32'h200, 0, 32'h4);   // 20
    add(32'h1FC, 0,0, 1,1, 32'h140, 32'h300, 0, 32'h200, 1, 32'h300); // 21 target mismatch
    add(32'h140, 0,0, 0,0, 32'h0,   32'h0,   1, 32'h300, 0, 32'h4);   // 22 new target learnt
    add(32'hFFFFFFFC, 0,0, 0,0, 32'h0, 32'h0, 0, 32'h0,  0, 32'h4);   // 23 pcF+4 wraps

    drive(32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      step($sformatf("row%0d", i), vq[i]);
    end

    // Stall two cycles with a predicted-taken branch held in D.
    step_args("stall0", 32'h140, 0,0, 0,0, 32'h0,   32'h0,   1, 32'h300, 0, 32'h4);
    step_args("stall1", 32'h144, 1,1, 0,0, 32'h0,   32'h0,   0, 32'h148, 0, 32'h4);
    step_args("stall2", 32'h144, 1,1, 0,0, 32'h0,   32'h0,   0, 32'h148, 0, 32'h4);
    step_args("stall3", 32'h144, 0,0, 0,0, 32'h0,   32'h0,   0, 32'h148, 0, 32'h4);
    step_args("stall4", 32'h140, 0,0, 1,1, 32'h140, 32'h300, 1, 32'h300, 0, 32'h300);

    // Mispredict with stall and flush both high: both slots must empty.
    step_args("coin0", 32'h148, 1,1, 1,1, 32'h144, 32'h400, 0, 32'h14C, 1, 32'h400);
    step_args("coin1", 32'h144, 0,0, 0,0, 32'h0,   32'h0,   1, 32'h400, 0, 32'h4);
    step_args("coin2", 32'h148, 0,0, 1,1, 32'h140, 32'h300, 0, 32'h14C, 1, 32'h300);

    // Flush alone bubbles the E slot.
    step_args("flush0", 32'h140, 0,0, 0,0, 32'h0,   32'h0,   1, 32'h300, 0, 32'h4);
    step_args("flush1", 32'h144, 0,1, 0,0, 32'h0,   32'h0,   1, 32'h400, 0, 32'h4);
    step_args("flush2", 32'h148, 0,0, 1,1, 32'h140, 32'h300, 0, 32'h14C, 1, 32'h300);

    // Mid-run reset overrides a coincident taken update.
    step_args("prerst", 32'h140, 0,0, 0,0, 32'h0,   32'h0,   1, 32'h300, 0, 32'h4);
    drive(32'h140, 1, 1, 1, 1, 32'h1C0, 32'h500);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(32'h140, 0, 0, 0, 0, 32'h0, 32'h0);
    peek_fetch("rst 0x140", 32'h140, 1'b0, 32'h144);
    peek_fetch("rst 0x144", 32'h144, 1'b0, 32'h148);
    peek_fetch("rst 0x1C0", 32'h1C0, 1'b0, 32'h1C4);
    cmp("rst redirectValid",  32'(bus.redirectValid),  32'h0);
    cmp("rst branchResolved", 32'(bus.branchResolved), 32'h0);
    @(posedge clk);
    #1;
    step_args("postrst", 32'h1C0, 0,0, 0,0, 32'h0, 32'h0, 0, 32'h1C4, 0, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
